// File: rtl/alu_seq_unit.sv
// Sequential RV32 ALU: decodes aluop/funct fields, runs the op under start/busy/done.
// Optional iterative multiplier compiled in with `define ALU_SEQ_MUL_EN.
module alu_seq_unit #(
    parameter int XLEN       = 32,
    parameter int FAST_SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy,
    output logic            done
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_ILL  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
        S_MUL   = 2'd3,
`endif
        S_DONE  = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [3:0]          dec;
    logic [SHAMT_W-1:0]  shamt;
    logic                is_shift, is_mul, iter, accept;
    logic [XLEN-1:0]     fast_res, acc, sh_nx;
    logic [CNT_W-1:0]    cnt;

    always_comb begin
        dec = OP_ILL;
        case (aluop)
            2'b00: dec = OP_ADD;
            2'b01: dec = OP_SUB;
            2'b10: begin
                if (!funct7_0) begin
                    case ({funct7_5, funct3})
                        4'b0000: dec = OP_ADD;
                        4'b1000: dec = OP_SUB;
                        4'b0001: dec = OP_SLL;
                        4'b0010: dec = OP_SLT;
                        4'b0011: dec = OP_SLTU;
                        4'b0100: dec = OP_XOR;
                        4'b0101: dec = OP_SRL;
                        4'b1101: dec = OP_SRA;
                        4'b0110: dec = OP_OR;
                        4'b0111: dec = OP_AND;
                        default: dec = OP_ILL;
                    endcase
                end
`ifdef ALU_SEQ_MUL_EN
                else if (funct3 == 3'b000) begin
                    dec = OP_MUL;
                end
`endif
            end
            default: begin
                case (funct3)
                    3'b000:  dec = OP_ADD;
                    3'b001:  dec = funct7_5 ? OP_ILL : OP_SLL;
                    3'b010:  dec = OP_SLT;
                    3'b011:  dec = OP_SLTU;
                    3'b100:  dec = OP_XOR;
                    3'b101:  dec = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110:  dec = OP_OR;
                    default: dec = OP_AND;
                endcase
            end
        endcase
    end

    assign shamt    = b[SHAMT_W-1:0];
    assign is_shift = (dec == OP_SLL) || (dec == OP_SRL) || (dec == OP_SRA);
    assign is_mul   = (dec == OP_MUL);
    assign iter     = is_shift && (FAST_SHIFT == 0) && (shamt != '0);
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);
    assign accept   = start && !busy;

    always_comb begin
        fast_res = '0;
        case (dec)
            OP_ADD:  fast_res = a + b;
            OP_SUB:  fast_res = a - b;
            OP_SLL:  fast_res = a << shamt;
            OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:  fast_res = a ^ b;
            OP_SRL:  fast_res = a >> shamt;
            OP_SRA:  fast_res = XLEN'($signed(a) >>> shamt);
            OP_OR:   fast_res = a | b;
            OP_AND:  fast_res = a & b;
            default: fast_res = '0;
        endcase
    end

    // one-bit step of the iterative shifter, op held in alu_ctrl
    always_comb begin
        sh_nx = acc >> 1;
        if (alu_ctrl == OP_SLL) begin
            sh_nx = acc << 1;
        end else if (alu_ctrl == OP_SRA) begin
            sh_nx = {acc[XLEN-1], acc[XLEN-1:1]};
        end
    end

`ifdef ALU_SEQ_MUL_EN
    logic [XLEN-1:0] mcand, mplier, prod_nx;

    assign prod_nx = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
        end else if (accept) begin
            mcand  <= a;
            mplier <= b;
        end else if (state == S_MUL) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_SHIFT: begin
                if (cnt == CNT_W'(1)) state_nx = S_DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                if (cnt == CNT_W'(1)) state_nx = S_DONE;
            end
`endif
            default: begin
                if (!start) begin
                    state_nx = S_IDLE;
                end else if (iter) begin
                    state_nx = S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
                end else if (is_mul) begin
                    state_nx = S_MUL;
`endif
                end else begin
                    state_nx = S_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctrl <= '0;
            result   <= '0;
            zero     <= 1'b0;
            illegal  <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
        end else if (accept) begin
            alu_ctrl <= dec;
            acc      <= is_mul ? '0 : a;
            cnt      <= is_mul ? CNT_W'(XLEN) : {1'b0, shamt};
            if (!iter && !is_mul) begin
                result  <= fast_res;
                zero    <= (fast_res == '0);
                illegal <= (dec == OP_ILL);
            end
        end else if (state == S_SHIFT) begin
            acc <= sh_nx;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                result  <= sh_nx;
                zero    <= (sh_nx == '0);
                illegal <= 1'b0;
            end
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state == S_MUL) begin
            acc <= prod_nx;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                result  <= prod_nx;
                zero    <= (prod_nx == '0);
                illegal <= 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: driver queues expectations, monitor checks done.
// Default build; expectations for the MUL vector follow ALU_SEQ_MUL_EN.
module tb_alu_seq_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  aluop;
    logic [2:0]  funct3;
    logic        funct7_5, funct7_0;
    logic [31:0] a, b;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero, illegal, busy, done;

    alu_seq_unit #(.XLEN(32), .FAST_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .aluop(aluop),
        .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .a(a), .b(b), .alu_ctrl(alu_ctrl), .result(result),
        .zero(zero), .illegal(illegal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic [3:0]  ctrl;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected none");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, ".result"}, result, e.res);
                chk({e.name, ".zero"}, {31'd0, zero}, {31'd0, e.z});
                chk({e.name, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
                chk({e.name, ".alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, e.ctrl});
                chk({e.name, ".latency"}, cyc - e.acc_edge + 1, e.lat);
                chk({e.name, ".busy"}, {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=1 after 200 cycles, expected 0");
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                         input logic f75, input logic f70,
                         input logic [31:0] va, input logic [31:0] vb);
        start    = 1'b1;
        aluop    = op;
        funct3   = f3;
        funct7_5 = f75;
        funct7_0 = f70;
        a        = va;
        b        = vb;
    endtask

    task automatic issue(input string nm, input logic [1:0] op,
                         input logic [2:0] f3, input logic f75,
                         input logic f70, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] er,
                         input logic ez, input logic eill,
                         input logic [3:0] ec, input int lat);
        exp_t e;
        wait_idle();
        drive(op, f3, f75, f70, va, vb);
        @(posedge clk);
        #1;
        start = 1'b0;
        e = '{nm, er, ez, eill, ec, lat, cyc};
        q.push_back(e);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        aluop = '0;
        funct3 = '0;
        funct7_5 = 1'b0;
        funct7_0 = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset.result", result, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);

        issue("sub", 2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7,
              32'hFFFF_FFFE, 1'b0, 1'b0, 4'd1, 1);
        issue("srai", 2'b11, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4,
              32'hF800_0000, 1'b0, 1'b0, 4'd7, 5);
        issue("slt", 2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,
              32'd1, 1'b0, 1'b0, 4'd3, 1);
        issue("sltu", 2'b10, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,
              32'd0, 1'b1, 1'b0, 4'd4, 1);
        issue("slli_ill", 2'b11, 3'b001, 1'b1, 1'b0, 32'h1234, 32'd3,
              32'd0, 1'b1, 1'b1, 4'd15, 1);
        issue("r_ill", 2'b10, 3'b001, 1'b1, 1'b0, 32'h1234, 32'd3,
              32'd0, 1'b1, 1'b1, 4'd15, 1);
`ifdef ALU_SEQ_MUL_EN
        issue("mul", 2'b10, 3'b000, 1'b0, 1'b1, 32'h1234_5678, 32'h10,
              32'h2345_6780, 1'b0, 1'b0, 4'd10, 33);
`else
        issue("mul_ill", 2'b10, 3'b000, 1'b0, 1'b1, 32'h1234_5678, 32'h10,
              32'd0, 1'b1, 1'b1, 4'd15, 1);
`endif
        issue("srl_hi_b", 2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h21,
              32'h4000_0000, 1'b0, 1'b0, 4'd6, 2);
        issue("sll_sh0", 2'b10, 3'b001, 1'b0, 1'b0, 32'hABCD, 32'h20,
              32'hABCD, 1'b0, 1'b0, 4'd2, 1);
        issue("sub_junk", 2'b01, 3'b111, 1'b1, 1'b1, 32'd10, 32'd10,
              32'd0, 1'b1, 1'b0, 4'd1, 1);
        issue("add_wrap", 2'b00, 3'b101, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,
              32'd0, 1'b1, 1'b0, 4'd0, 1);
        // back-to-back single-cycle ops, each accepted in the previous DONE cycle
        issue("b2b_xor", 2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0,
              32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 4'd5, 1);
        issue("b2b_andi", 2'b11, 3'b111, 1'b1, 1'b0, 32'h1234_5678,
              32'h0000_FFFF, 32'h0000_5678, 1'b0, 1'b0, 4'd9, 1);
        issue("b2b_or", 2'b10, 3'b110, 1'b0, 1'b0, 32'd1, 32'd2,
              32'd3, 1'b0, 1'b0, 4'd8, 1);
        issue("b2b_srl", 2'b10, 3'b101, 1'b0, 1'b0, 32'h0000_0100, 32'd4,
              32'h0000_0010, 1'b0, 1'b0, 4'd6, 5);

        wait_idle();
        repeat (2) @(negedge clk);
        drive(2'b10, 3'b001, 1'b0, 1'b0, 32'd1, 32'd31);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        drive(2'b00, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9);
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("busy_ign.busy", {31'd0, busy}, 32'd1);
        chk("busy_ign.alu_ctrl", {28'd0, alu_ctrl}, 32'd2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst.busy", {31'd0, busy}, 32'd0);
        chk("mid_rst.done", {31'd0, done}, 32'd0);
        chk("mid_rst.result", result, 32'd0);
        chk("mid_rst.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        repeat (35) @(negedge clk);
        issue("add_post", 2'b00, 3'b000, 1'b0, 1'b0, 32'd3, 32'd4,
              32'd7, 1'b0, 1'b0, 4'd0, 1);

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results pending, expected 0", q.size());
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, sequential successor to the ALU control decoder for the multicycle RV32 core.
- Fully decodes aluop/funct3/funct7 into a 4-bit ALU operation and executes it on latched operands under a start/busy/done handshake.
- Shifts execute either iteratively (one bit per cycle) or in a single cycle; an optional iterative multiplier can be compiled in.
- Sits between the control FSM (drives start, waits for done) and the register/ALUOut datapath.

Parameters:
- XLEN, 32: operand/result width; power of two, 8..64. Derived localparam SHAMT_W = $clog2(XLEN).
- FAST_SHIFT, 0: 0 = iterative shifts, 1 bit per cycle; 1 = all shifts complete with latency 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- aluop  in  2  00 add, 01 sub, 10 R-type decode, 11 I-type decode.
- funct3  in  3  instruction funct3.
- funct7_5  in  1  instruction bit 30.
- funct7_0  in  1  instruction bit 25 (M-extension select).
- a  in  XLEN  operand A.
- b  in  XLEN  operand B / immediate.
- alu_ctrl  out  4  registered decoded op of the accepted request.
- result  out  XLEN  registered result; held until next accept.
- zero  out  1  result == 0, registered with result.
- illegal  out  1  accepted request had an unsupported encoding.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- alu_ctrl encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL; 15 illegal.
- aluop 00 -> ADD; 01 -> SUB; funct fields ignored.
- aluop 10 with funct7_0=0: {funct7_5,funct3}:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - Any other combination is illegal.
- aluop 11: funct3 gives ADDI/SLTI/SLTIU/XORI/ORI/ANDI; funct7_5 ignored except shifts: 001 requires funct7_5=0 (SLLI); 101 selects SRLI (0) or SRAI (1). SLLI with funct7_5=1 is illegal.
- Arithmetic is modulo 2^XLEN. SLT is signed, SLTU unsigned; the result is zero-extended 0/1. Shift amount is b[SHAMT_W-1:0]; upper bits of b are ignored.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - MUL: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE unless a new start is accepted.
- Accept:
  - start=1 while busy=0, in IDLE or DONE, accepts the request.
  - alu_ctrl and illegal are registered at the accept edge.
  - start while busy=1 is ignored; no queuing.
- Latency: done is high L cycles after the accept cycle.
  - L=1 for non-shift ops, illegal ops, shamt=0, and FAST_SHIFT=1.
  - L=1+shamt for iterative shifts.
  - L=1+XLEN for MUL.
- Iterative shift:
  - Load acc=a and cnt=shamt.
  - Each SHIFT cycle shifts acc one position (SRA replicates the MSB) and decrements cnt.
  - At cnt 1->0 the result is written and the FSM goes to DONE.
- Illegal op: result=0, zero=1, illegal=1, L=1.
- result, zero, and illegal change only at the edge entering DONE. alu_ctrl changes only at accept.
- Reset (any state, including mid-operation) -> IDLE with busy=0, done=0, result=0, zero=0, illegal=0, alu_ctrl=0. Any partial operation is discarded.
- Back-to-back: start asserted during the DONE cycle is accepted. done then drops the next cycle unless the new op also has L=1, in which case done stays high with the new result.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - aluop=10, funct7_0=1, funct3=000 -> MUL, giving the low XLEN bits of a*b.
  - Implemented as shift-add, one multiplier bit per cycle in state MUL, XLEN cycles.
  - Other funct3 values with funct7_0=1 are illegal.
- Undefined: no MUL state or logic; any aluop=10 request with funct7_0=1 is illegal.

Test Plan:
- Reset, then aluop=10, {f7_5,f3}=1000, a=5, b=7, start -> done after 1 cycle, result=0xFFFFFFFE, alu_ctrl=1, zero=0.
- FAST_SHIFT=0: aluop=11, f3=101, f7_5=1, a=0x80000000, b=4 -> busy for 4 cycles, done at cycle 5, result=0xF8000000, alu_ctrl=7.
- aluop=10, f3=010 SLT, a=0xFFFFFFFF, b=1 -> result=1; same operands with f3=011 SLTU -> result=0.
- Start during busy (SLL, shamt=31) is ignored; rst at cycle 10 -> busy=0, result=0, done never pulses; a new ADD 3+4 afterwards -> result=7.
- aluop=11, f3=001, f7_5=1 -> illegal=1, result=0, zero=1, done after 1 cycle.
- With ALU_SEQ_MUL_EN: a=0x12345678, b=0x10 -> done at cycle 33, result=0x23456780. Without the macro, the same request -> illegal=1.
